// File: rtl/operand_fwd_stage.sv
// Decode-to-execute boundary register with per-operand EX/MEM/WB bypass,
// load-use bubble insertion and decode stall generation.

module operand_fwd_mux #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic [AW-1:0] src_i,
  input  logic [DW-1:0] rf_data_i,
  input  logic          ex_en_i,
  input  logic [AW-1:0] ex_rd_i,
  input  logic [DW-1:0] ex_result_i,
  input  logic          mem_regwen_i,
  input  logic [AW-1:0] mem_rd_i,
  input  logic [DW-1:0] mem_result_i,
  input  logic          wb_regwen_i,
  input  logic [AW-1:0] wb_rd_i,
  input  logic [DW-1:0] wb_data_i,
  output logic [DW-1:0] data_o
);
  // Youngest producer wins; WB covers the bank's stale read in its write cycle.
  always_comb begin
    data_o = rf_data_i;
    if (src_i == '0)                              data_o = '0;
    else if (ex_en_i && ex_rd_i == src_i)         data_o = ex_result_i;
    else if (mem_regwen_i && mem_rd_i == src_i)   data_o = mem_result_i;
    else if (wb_regwen_i && wb_rd_i == src_i)     data_o = wb_data_i;
  end
endmodule

module operand_fwd_stage #(
  parameter int WIDTH_ADDR_LENGTH = 5,
  parameter int WIDTH_DATA_LENGTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [WIDTH_ADDR_LENGTH-1:0] id_rs1,
  input  logic [WIDTH_ADDR_LENGTH-1:0] id_rs2,
  input  logic                         id_rs1_used,
  input  logic                         id_rs2_used,
  input  logic [WIDTH_DATA_LENGTH-1:0] rf_dataA,
  input  logic [WIDTH_DATA_LENGTH-1:0] rf_dataB,
  input  logic [WIDTH_ADDR_LENGTH-1:0] id_rd,
  input  logic                         id_regwen,
  input  logic                         id_memread,
  input  logic [WIDTH_DATA_LENGTH-1:0] ex_result,
  input  logic [WIDTH_ADDR_LENGTH-1:0] mem_rd,
  input  logic                         mem_regwen,
  input  logic [WIDTH_DATA_LENGTH-1:0] mem_result,
  input  logic [WIDTH_ADDR_LENGTH-1:0] wb_rd,
  input  logic                         wb_regwen,
  input  logic [WIDTH_DATA_LENGTH-1:0] wb_data,
  input  logic                         flush,
  input  logic                         hold,
  output logic                         stall,
  output logic                         ex_valid,
  output logic [WIDTH_DATA_LENGTH-1:0] ex_opA,
  output logic [WIDTH_DATA_LENGTH-1:0] ex_opB,
  output logic [WIDTH_ADDR_LENGTH-1:0] ex_rd,
  output logic                         ex_regwen,
  output logic                         ex_memread
);
  localparam int NUM_OPS = 2;
  localparam int AW = WIDTH_ADDR_LENGTH;
  localparam int DW = WIDTH_DATA_LENGTH;

  logic [NUM_OPS-1:0][AW-1:0] src;
  logic [NUM_OPS-1:0][DW-1:0] rf_data;
  logic [NUM_OPS-1:0][DW-1:0] fwd_data;
  logic [NUM_OPS-1:0]         src_used;
  logic [NUM_OPS-1:0]         ld_hit;

  logic          ex_valid_q,   ex_valid_d;
  logic [DW-1:0] ex_opA_q,     ex_opA_d;
  logic [DW-1:0] ex_opB_q,     ex_opB_d;
  logic [AW-1:0] ex_rd_q,      ex_rd_d;
  logic          ex_regwen_q,  ex_regwen_d;
  logic          ex_memread_q, ex_memread_d;

  logic ex_fwd_en;
  logic luh;

  assign src      = {id_rs2, id_rs1};
  assign rf_data  = {rf_dataB, rf_dataA};
  assign src_used = {id_rs2_used, id_rs1_used};

  // A load in EX has no data yet, so it must not feed the EX bypass.
  assign ex_fwd_en = ex_valid_q & ex_regwen_q & ~ex_memread_q;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    operand_fwd_mux #(.AW(AW), .DW(DW)) u_mux (
      .src_i        (src[i]),
      .rf_data_i    (rf_data[i]),
      .ex_en_i      (ex_fwd_en),
      .ex_rd_i      (ex_rd_q),
      .ex_result_i  (ex_result),
      .mem_regwen_i (mem_regwen),
      .mem_rd_i     (mem_rd),
      .mem_result_i (mem_result),
      .wb_regwen_i  (wb_regwen),
      .wb_rd_i      (wb_rd),
      .wb_data_i    (wb_data),
      .data_o       (fwd_data[i])
    );
    assign ld_hit[i] = src_used[i] & (src[i] == ex_rd_q);
  end

  assign luh   = id_valid & ex_valid_q & ex_memread_q & (ex_rd_q != '0) & (|ld_hit);
  assign stall = luh | hold;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_opA_d     = ex_opA_q;
    ex_opB_d     = ex_opB_q;
    ex_rd_d      = ex_rd_q;
    ex_regwen_d  = ex_regwen_q;
    ex_memread_d = ex_memread_q;
    if (!hold) begin
      if (flush || luh) begin
        ex_valid_d   = 1'b0;
        ex_opA_d     = '0;
        ex_opB_d     = '0;
        ex_rd_d      = '0;
        ex_regwen_d  = 1'b0;
        ex_memread_d = 1'b0;
      end else begin
        ex_valid_d   = id_valid;
        ex_opA_d     = fwd_data[0];
        ex_opB_d     = fwd_data[1];
        ex_rd_d      = id_rd;
        ex_regwen_d  = id_valid & id_regwen;
        ex_memread_d = id_valid & id_memread;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_opA_q     <= '0;
      ex_opB_q     <= '0;
      ex_rd_q      <= '0;
      ex_regwen_q  <= 1'b0;
      ex_memread_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_opA_q     <= ex_opA_d;
      ex_opB_q     <= ex_opB_d;
      ex_rd_q      <= ex_rd_d;
      ex_regwen_q  <= ex_regwen_d;
      ex_memread_q <= ex_memread_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_opA     = ex_opA_q;
  assign ex_opB     = ex_opB_q;
  assign ex_rd      = ex_rd_q;
  assign ex_regwen  = ex_regwen_q;
  assign ex_memread = ex_memread_q;
endmodule

// File: tb/tb_operand_fwd_stage.sv
// Directed bench for operand_fwd_stage: reset, bypass priority, x0 guard,
// load-use bubble, hold and flush.

module tb_operand_fwd_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_regwen, id_memread;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [31:0] rf_dataA, rf_dataB, ex_result, mem_result, wb_data;
  logic        mem_regwen, wb_regwen, flush, hold;
  logic        stall, ex_valid, ex_regwen, ex_memread;
  logic [31:0] ex_opA, ex_opB;
  logic [4:0]  ex_rd;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  operand_fwd_stage #(.WIDTH_ADDR_LENGTH(5), .WIDTH_DATA_LENGTH(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .rf_dataA(rf_dataA), .rf_dataB(rf_dataB), .id_rd(id_rd),
    .id_regwen(id_regwen), .id_memread(id_memread), .ex_result(ex_result),
    .mem_rd(mem_rd), .mem_regwen(mem_regwen), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_regwen(wb_regwen), .wb_data(wb_data),
    .flush(flush), .hold(hold), .stall(stall), .ex_valid(ex_valid),
    .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_rd(ex_rd),
    .ex_regwen(ex_regwen), .ex_memread(ex_memread)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are read 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_regwen = 0; id_memread = 0; rf_dataA = 0; rf_dataB = 0;
  endtask

  initial begin
    clr_id();
    rst = 1; ex_result = 0; mem_rd = 0; mem_regwen = 0; mem_result = 0;
    wb_rd = 0; wb_regwen = 0; wb_data = 0; flush = 0; hold = 0;

    // Reset with a valid instruction presented
    id_valid = 1; id_rd = 5'd3; id_regwen = 1; id_memread = 1;
    rf_dataA = 32'h1; rf_dataB = 32'h2; id_rs1 = 5'd1; id_rs2 = 5'd2;
    step(); step();
    chk("rst_valid",   {31'b0, ex_valid},   32'h0);
    chk("rst_opA",     ex_opA,              32'h0);
    chk("rst_opB",     ex_opB,              32'h0);
    chk("rst_rd",      {27'b0, ex_rd},      32'h0);
    chk("rst_regwen",  {31'b0, ex_regwen},  32'h0);
    chk("rst_memread", {31'b0, ex_memread}, 32'h0);
    chk("rst_stall",   {31'b0, stall},      32'h0);
    rst = 0;

    // add x5 enters EX
    clr_id();
    id_valid = 1; id_rd = 5'd5; id_regwen = 1;
    step();
    chk("add_valid",  {31'b0, ex_valid},  32'h1);
    chk("add_rd",     {27'b0, ex_rd},     32'h5);
    chk("add_regwen", {31'b0, ex_regwen}, 32'h1);

    // EX bypass beats stale bank data
    clr_id();
    id_valid = 1; id_rs1 = 5'd5; id_rs1_used = 1; rf_dataA = 32'hDEAD_BEEF;
    id_rd = 5'd6; id_regwen = 1; ex_result = 32'h0000_1234;
    step();
    chk("ex_fwd_opA", ex_opA, 32'h0000_1234);

    // MEM over WB, then WB alone, then bank
    clr_id();
    id_valid = 1; id_rs2 = 5'd7; id_rs2_used = 1; rf_dataB = 32'h99;
    mem_rd = 5'd7; mem_regwen = 1; mem_result = 32'h11;
    wb_rd = 5'd7; wb_regwen = 1; wb_data = 32'h22;
    step();
    chk("prio_mem", ex_opB, 32'h11);
    chk("prio_opA_x0", ex_opA, 32'h0);
    mem_regwen = 0;
    step();
    chk("prio_wb", ex_opB, 32'h22);
    wb_regwen = 0;
    step();
    chk("prio_rf", ex_opB, 32'h99);

    // x0 never forwarded, bank value ignored
    clr_id();
    id_valid = 1; id_rs1 = 5'd0; id_rs1_used = 1; rf_dataA = 32'h77;
    wb_rd = 5'd0; wb_regwen = 1; wb_data = 32'hFFFF_FFFF;
    mem_rd = 5'd0; mem_regwen = 1; mem_result = 32'h55;
    step();
    chk("x0_opA", ex_opA, 32'h0);
    wb_regwen = 0; mem_regwen = 0;

    // lw x3 enters EX
    clr_id();
    id_valid = 1; id_rd = 5'd3; id_regwen = 1; id_memread = 1;
    step();
    chk("lw_memread", {31'b0, ex_memread}, 32'h1);

    // dependent add: one bubble, then MEM supplies the load data
    clr_id();
    id_valid = 1; id_rs1 = 5'd3; id_rs1_used = 1; id_rd = 5'd4; id_regwen = 1;
    rf_dataA = 32'h0BAD_0BAD; ex_result = 32'h0000_0333;
    #1;
    chk("luh_stall", {31'b0, stall}, 32'h1);
    step();
    chk("luh_bubble_valid",  {31'b0, ex_valid},  32'h0);
    chk("luh_bubble_regwen", {31'b0, ex_regwen}, 32'h0);
    chk("luh_stall_clear",   {31'b0, stall},     32'h0);
    mem_rd = 5'd3; mem_regwen = 1; mem_result = 32'hCAFE_F00D;
    step();
    chk("luh_opA",   ex_opA,             32'hCAFE_F00D);
    chk("luh_valid", {31'b0, ex_valid},  32'h1);
    chk("luh_rd",    {27'b0, ex_rd},     32'h4);
    mem_regwen = 0;

    // hold freezes the stage for 3 cycles
    clr_id();
    id_valid = 1; id_rd = 5'd9; id_regwen = 1; id_rs1 = 5'd1; id_rs1_used = 1;
    rf_dataA = 32'h1;
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_stall", {31'b0, stall}, 32'h1);
      step();
      chk("hold_opA",   ex_opA,            32'hCAFE_F00D);
      chk("hold_rd",    {27'b0, ex_rd},    32'h4);
      chk("hold_valid", {31'b0, ex_valid}, 32'h1);
    end
    hold = 0;

    // flush kills the entering instruction
    flush = 1;
    step();
    chk("flush_valid",  {31'b0, ex_valid},  32'h0);
    chk("flush_regwen", {31'b0, ex_regwen}, 32'h0);
    chk("flush_rd",     {27'b0, ex_rd},     32'h0);
    flush = 0;

    // hold with a pending load-use keeps the load in EX
    clr_id();
    id_valid = 1; id_rd = 5'd3; id_regwen = 1; id_memread = 1;
    step();
    clr_id();
    id_valid = 1; id_rs2 = 5'd3; id_rs2_used = 1; id_rd = 5'd8; id_regwen = 1;
    hold = 1;
    step();
    chk("hold_luh_memread", {31'b0, ex_memread}, 32'h1);
    chk("hold_luh_rd",      {27'b0, ex_rd},      32'h3);
    hold = 0;

    // flush together with load-use: bubble and stall
    flush = 1;
    #1;
    chk("flush_luh_stall", {31'b0, stall}, 32'h1);
    step();
    chk("flush_luh_valid", {31'b0, ex_valid}, 32'h0);
    flush = 0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
